// File: rtl/mtimer_if.sv
// Data-side load/store bus seen by memory-mapped peripherals.
// The processor drives the request; the peripheral returns combinational hit/read data.
interface mtimer_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;

  modport master (
    output rd_en,
    output wr_en,
    output addr,
    output wdata,
    input  rdata,
    input  hit
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  addr,
    input  wdata,
    output rdata,
    output hit
  );
endinterface

// File: rtl/mtimer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp with prescaler, memory-mapped on the
// data bus, producing a registered level interrupt while enabled and mtime >= mtimecmp.
module mtimer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic      clk,
  input  logic      rst,
  mtimer_if.slave   bus,
  output logic      timer_interrupt
);

  localparam logic [2:0] SEL_MTIME_LO = 3'd0;
  localparam logic [2:0] SEL_MTIME_HI = 3'd1;
  localparam logic [2:0] SEL_CMP_LO   = 3'd2;
  localparam logic [2:0] SEL_CMP_HI   = 3'd3;
  localparam logic [2:0] SEL_CTRL     = 3'd4;
  localparam logic [2:0] SEL_PRESC    = 3'd5;

  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = {{(PRESC_W-1){1'b0}}, 1'b1};

  logic [63:0]        mtime_r;
  logic [63:0]        mtimecmp_r;
  logic               en_r;
  logic               irq_en_r;
  logic [PRESC_W-1:0] presc_r;
  logic [PRESC_W-1:0] presc_cnt_r;
  logic               irq_r;

  logic               hit_s;
  logic [2:0]         sel_s;
  logic               wr_hit_s;
  logic               tick_s;
  logic               presc_clr_s;
  logic [63:0]        mtime_nxt_s;
  logic [PRESC_W-1:0] presc_cnt_nxt_s;
  logic               irq_cond_s;
  logic [31:0]        rdata_s;

  // Address decode: 32-byte window, word-aligned accesses only.
  always_comb begin
    hit_s    = (bus.addr[31:5] == BASE_ADDR[31:5]) && (bus.addr[1:0] == 2'b00);
    sel_s    = bus.addr[4:2];
    wr_hit_s = hit_s && bus.wr_en;
  end

  // Tick and prescaler-restart strobes, all from pre-edge register values.
  always_comb begin
    tick_s      = en_r && (presc_cnt_r == presc_r);
    presc_clr_s = wr_hit_s && ((sel_s == SEL_CTRL) || (sel_s == SEL_PRESC));
    irq_cond_s  = irq_en_r && (mtime_r >= mtimecmp_r);
  end

  // Next mtime: a software write to either half wins over a tick, with no carry.
  always_comb begin
    mtime_nxt_s = mtime_r;
    if (wr_hit_s && (sel_s == SEL_MTIME_LO)) begin
      mtime_nxt_s = {mtime_r[63:32], bus.wdata};
    end else if (wr_hit_s && (sel_s == SEL_MTIME_HI)) begin
      mtime_nxt_s = {bus.wdata, mtime_r[31:0]};
    end else if (tick_s) begin
      mtime_nxt_s = mtime_r + 64'd1;
    end else begin
      mtime_nxt_s = mtime_r;
    end
  end

  // Next prescaler count: held at zero while disabled, wraps on tick.
  always_comb begin
    presc_cnt_nxt_s = presc_cnt_r;
    if (presc_clr_s || !en_r || tick_s) begin
      presc_cnt_nxt_s = PRESC_ZERO;
    end else begin
      presc_cnt_nxt_s = presc_cnt_r + PRESC_ONE;
    end
  end

  // mtime register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_r <= 64'h0;
    end else begin
      mtime_r <= mtime_nxt_s;
    end
  end

  // Prescaler counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt_r <= PRESC_ZERO;
    end else begin
      presc_cnt_r <= presc_cnt_nxt_s;
    end
  end

  // Software-written configuration: compare value, control and prescaler divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
      en_r       <= 1'b0;
      irq_en_r   <= 1'b0;
      presc_r    <= PRESC_ZERO;
    end else if (wr_hit_s) begin
      case (sel_s)
        SEL_CMP_LO: mtimecmp_r[31:0]  <= bus.wdata;
        SEL_CMP_HI: mtimecmp_r[63:32] <= bus.wdata;
        SEL_CTRL: begin
          en_r     <= bus.wdata[0];
          irq_en_r <= bus.wdata[1];
        end
        SEL_PRESC:  presc_r <= bus.wdata[PRESC_W-1:0];
        default: begin
          mtimecmp_r <= mtimecmp_r;
        end
      endcase
    end
  end

  // Interrupt level, one cycle behind the compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= irq_cond_s;
    end
  end

  // Read mux; reserved and unselected locations read as zero.
  always_comb begin
    rdata_s = 32'h0;
    if (hit_s && bus.rd_en) begin
      case (sel_s)
        SEL_MTIME_LO: rdata_s = mtime_r[31:0];
        SEL_MTIME_HI: rdata_s = mtime_r[63:32];
        SEL_CMP_LO:   rdata_s = mtimecmp_r[31:0];
        SEL_CMP_HI:   rdata_s = mtimecmp_r[63:32];
        SEL_CTRL:     rdata_s = {30'h0, irq_en_r, en_r};
        SEL_PRESC:    rdata_s = 32'(presc_r);
        default:      rdata_s = 32'h0;
      endcase
    end else begin
      rdata_s = 32'h0;
    end
  end

  assign bus.hit         = hit_s;
  assign bus.rdata       = rdata_s;
  assign timer_interrupt = irq_r;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: a cycle-level behavioural model checked every cycle,
// plus directed reads against hand-computed constants.
module tb_mtimer;
  localparam logic [31:0] BASE = 32'h0000_0400;

  logic clk = 1'b0;
  logic rst;
  logic timer_interrupt;
  mtimer_if bus();

  mtimer #(.BASE_ADDR(BASE), .PRESC_W(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .timer_interrupt(timer_interrupt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the timer as software sees it.
  logic [63:0] m_time;
  logic [63:0] m_cmp;
  logic        m_en;
  logic        m_ie;
  int          m_presc;
  int          m_run;   // enabled cycles since the prescaler last restarted
  logic        m_irq;

  task automatic expect32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_hit(input logic [31:0] a);
    return (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
    if (!rd || !model_hit(a)) return 32'h0;
    case (a[4:0])
      5'h00:   return m_time[31:0];
      5'h04:   return m_time[63:32];
      5'h08:   return m_cmp[31:0];
      5'h0C:   return m_cmp[63:32];
      5'h10:   return {30'h0, m_ie, m_en};
      5'h14:   return m_presc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_time  = 64'h0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en    = 1'b0;
    m_ie    = 1'b0;
    m_presc = 0;
    m_run   = 0;
    m_irq   = 1'b0;
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_step();
    logic        tick;
    logic        en_pre;
    logic        restart;
    logic [63:0] t;
    if (rst) begin
      model_reset();
      return;
    end
    en_pre  = m_en;
    tick    = m_en && ((m_run % (m_presc + 1)) == m_presc);
    m_irq   = m_ie && (m_time >= m_cmp);
    t       = tick ? m_time + 64'd1 : m_time;
    restart = 1'b0;
    if (bus.wr_en && model_hit(bus.addr)) begin
      case (bus.addr[4:0])
        5'h00: t = {m_time[63:32], bus.wdata};
        5'h04: t = {bus.wdata, m_time[31:0]};
        5'h08: m_cmp[31:0]  = bus.wdata;
        5'h0C: m_cmp[63:32] = bus.wdata;
        5'h10: begin m_en = bus.wdata[0]; m_ie = bus.wdata[1]; restart = 1'b1; end
        5'h14: begin m_presc = int'(bus.wdata[15:0]); restart = 1'b1; end
        default: ;
      endcase
    end
    m_time = t;
    m_run  = (restart || !en_pre) ? 0 : m_run + 1;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(posedge clk) begin
    #1;
    expect32("irq_model", {31'h0, timer_interrupt}, {31'h0, m_irq});
    expect32("hit_model", {31'h0, bus.hit}, {31'h0, model_hit(bus.addr)});
    expect32("rdata_model", bus.rdata, model_read(bus.rd_en, bus.addr));
  end

  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick_cycle();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b1;
    bus.addr  = a;
    bus.wdata = d;
    tick_cycle();
    bus.wr_en = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
  endtask

  // Read between edges and compare with a literal, pinning the model as well.
  task automatic check_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.rd_en = 1'b1;
    bus.addr  = a;
    #1;
    expect32(name, bus.rdata, exp);
    expect32({name, "_ref"}, model_read(1'b1, a), exp);
    bus.rd_en = 1'b0;
    bus.addr  = 32'h0;
  endtask

  task automatic check_irq(input logic exp, input string name);
    expect32(name, {31'h0, timer_interrupt}, {31'h0, exp});
  endtask

  initial begin
    rst       = 1'b1;
    bus.rd_en = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = 32'h0;
    bus.wdata = 32'h0;
    model_reset();
    @(negedge clk);
    idle(3);
    rst = 1'b0;

    // Reset values
    check_rd(BASE + 32'h00, 32'h0, "rst_mtime_lo");
    check_rd(BASE + 32'h04, 32'h0, "rst_mtime_hi");
    check_rd(BASE + 32'h08, 32'hFFFF_FFFF, "rst_cmp_lo");
    check_rd(BASE + 32'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    check_rd(BASE + 32'h10, 32'h0, "rst_ctrl");
    check_irq(1'b0, "rst_irq");
    idle(100);
    check_rd(BASE + 32'h00, 32'h0, "idle_mtime");

    // Prescaler 3: one tick every four cycles after the enabling write
    bus_write(BASE + 32'h14, 32'd3);
    bus_write(BASE + 32'h10, 32'd1);
    idle(40);
    check_rd(BASE + 32'h00, 32'd10, "presc3_mtime");
    check_rd(BASE + 32'h14, 32'd3, "presc_rb");
    check_rd(BASE + 32'h10, 32'd1, "ctrl_rb");

    // Interrupt timing with PRESC=0
    bus_write(BASE + 32'h10, 32'd0);
    bus_write(BASE + 32'h00, 32'd0);
    bus_write(BASE + 32'h04, 32'd0);
    bus_write(BASE + 32'h14, 32'd0);
    bus_write(BASE + 32'h0C, 32'd0);
    bus_write(BASE + 32'h08, 32'd20);
    bus_write(BASE + 32'h10, 32'd3);
    idle(20);
    check_rd(BASE + 32'h00, 32'd20, "irq_mtime20");
    check_irq(1'b0, "irq_not_yet");
    idle(1);
    check_irq(1'b1, "irq_rise");
    check_rd(BASE + 32'h00, 32'd21, "presc0_step");
    bus_write(BASE + 32'h08, 32'd1000);
    check_irq(1'b1, "irq_hold_on_cmp_write");
    idle(1);
    check_irq(1'b0, "irq_fall");

    // Carry from low to high half
    bus_write(BASE + 32'h10, 32'd0);
    bus_write(BASE + 32'h00, 32'hFFFF_FFFE);
    bus_write(BASE + 32'h04, 32'd0);
    bus_write(BASE + 32'h10, 32'd1);
    idle(2);
    check_rd(BASE + 32'h00, 32'h0, "carry_lo");
    check_rd(BASE + 32'h04, 32'h1, "carry_hi");

    // All-ones mtime: fires against reset-valued compare, then wraps to zero
    bus_write(BASE + 32'h10, 32'd0);
    bus_write(BASE + 32'h00, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h04, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h08, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h0C, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h10, 32'd2);
    idle(1);
    check_irq(1'b1, "irq_all_ones");
    bus_write(BASE + 32'h10, 32'd3);
    idle(1);
    check_rd(BASE + 32'h00, 32'h0, "wrap_lo");
    check_rd(BASE + 32'h04, 32'h0, "wrap_hi");

    // Write/tick collision
    bus_write(BASE + 32'h04, 32'd7);
    bus_write(BASE + 32'h00, 32'd5);
    check_rd(BASE + 32'h00, 32'd5, "collide_lo");
    check_rd(BASE + 32'h04, 32'd7, "collide_hi");
    idle(1);
    check_rd(BASE + 32'h00, 32'd6, "collide_next");

    // Decode: misaligned, out-of-window and reserved accesses
    bus_write(BASE + 32'h10, 32'd0);
    bus_write(BASE + 32'h00, 32'h55);
    bus_write(BASE + 32'h02, 32'h1234);
    bus_write(BASE + 32'h20, 32'h99);
    bus_write(BASE + 32'h18, 32'hAB);
    check_rd(BASE + 32'h00, 32'h55, "decode_lo_kept");
    check_rd(BASE + 32'h18, 32'h0, "reserved_rd");
    check_rd(BASE + 32'h02, 32'h0, "misaligned_rd");
    bus.addr = BASE + 32'h02;
    #1;
    expect32("misaligned_hit", {31'h0, bus.hit}, 32'h0);
    bus.addr = BASE + 32'h20;
    #1;
    expect32("outside_hit", {31'h0, bus.hit}, 32'h0);
    bus.addr = 32'h0;

    // Asynchronous reset with the interrupt pending
    @(negedge clk);
    bus_write(BASE + 32'h04, 32'd0);
    bus_write(BASE + 32'h00, 32'd0);
    bus_write(BASE + 32'h0C, 32'd0);
    bus_write(BASE + 32'h08, 32'd5);
    bus_write(BASE + 32'h10, 32'd3);
    idle(10);
    check_irq(1'b1, "irq_before_rst");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_irq(1'b0, "async_rst_irq");
    check_rd(BASE + 32'h00, 32'h0, "async_rst_mtime");
    tick_cycle();
    rst = 1'b0;
    idle(5);
    check_rd(BASE + 32'h00, 32'h0, "post_rst_mtime");
    check_irq(1'b0, "post_rst_irq");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped RISC-V machine timer, the source of the processor's `timer_interrupt` input.
- Responds to the processor's data-side load/store bus, in parallel with data memory, over a 64-bit `mtime`/`mtimecmp` pair plus control and prescaler registers.
- Drives a registered level interrupt whenever enabled and `mtime >= mtimecmp`.

Parameters:
- BASE_ADDR, 32'h0000_0400, byte base address of the 32-byte register window (aligned to 32 bytes).
- PRESC_W, 16, width of the prescaler divider register and prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- rd_en  input  1  load strobe from the controller.
- wr_en  input  1  store strobe from the controller.
- addr  input  32  byte address (ALU result).
- wdata  input  32  store data (rs2 value).
- rdata  output  32  combinational read data; 0 when not hit or `rd_en`=0.
- hit  output  1  combinational: `addr[31:5]==BASE_ADDR[31:5]` and `addr[1:0]==0`.
- timer_interrupt  output  1  registered machine-timer interrupt level.

Behaviour:
- Register map (offset from BASE_ADDR, word access only):
  - 0x00 MTIME_LO, 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 EN, bit1 IRQ_EN, other bits read 0
  - 0x14 PRESC: bits[PRESC_W-1:0]
  - 0x18, 0x1C: reserved, read 0, writes ignored
- Reset values (async, immediate on `rst`=1):
  - `mtime`=0, `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PRESC=0, `presc_cnt`=0, `timer_interrupt`=0.
- Reads:
  - Combinational, same cycle.
  - `rdata` = selected register when `hit` & `rd_en`, else 0.
  - Read of MTIME_LO/HI returns the current register value; no atomic 64-bit snapshot. Software uses the hi-lo-hi sequence.
- Writes:
  - Take effect on the clock edge when `hit` & `wr_en`.
  - Misaligned or out-of-window addresses: `hit`=0, no effect.
  - A half write replaces only that 32-bit half.
- Prescaler/counting:
  - When EN=1: `presc_cnt` increments each cycle. When `presc_cnt`==PRESC, it wraps to 0 and `mtime` increments by 1 that same edge.
  - PRESC=0 therefore increments `mtime` every cycle; PRESC=N increments every N+1 cycles.
  - When EN=0: `mtime` holds and `presc_cnt` is held at 0.
  - A write to PRESC or CTRL clears `presc_cnt` to 0.
  - `mtime` wraps from 2^64-1 to 0 with no flag.
- Simultaneous events:
  - Software write to MTIME_LO/HI on the same edge as a tick: the write wins for the whole 64-bit register. The tick is dropped and no carry propagates into the untouched half.
  - Write to PRESC on a tick edge: the tick still occurs; `presc_cnt` becomes 0.
- Interrupt:
  - Each edge, `timer_interrupt` <= IRQ_EN & (`mtime` >= `mtimecmp`), 64-bit unsigned compare on pre-edge register values.
  - Latency: one cycle after the condition becomes true or false.
  - Level only, no latching. Cleared only by raising `mtimecmp`, lowering `mtime`, or clearing IRQ_EN.
  - With the reset `mtimecmp` it never fires, except when `mtime` is all ones.
- Reset mid-operation: all state returns to reset values asynchronously; the pending interrupt drops immediately.

Test Plan:
- Reset then read:
  - Read 0x00/0x04 -> 0; read 0x08/0x0C -> FFFF_FFFF; CTRL=0; `timer_interrupt`=0.
  - Idle 100 cycles -> `mtime` still 0.
- Count with prescaler:
  - Write PRESC=3, CTRL=1 (EN), then wait 40 cycles -> MTIME_LO=10, ±1 per the write-edge alignment (exactly 10 when counting from the edge after the CTRL write).
  - With PRESC=0 -> +1 per cycle.
- Interrupt timing:
  - Setup: MTIMECMP_HI=0, MTIMECMP_LO=20, CTRL=3, PRESC=0 from `mtime`=0.
  - `timer_interrupt` rises exactly one cycle after `mtime` reaches 20.
  - Write MTIMECMP_LO=1000 -> `timer_interrupt` falls the following cycle.
- Carry and wrap:
  - Carry: write MTIME_LO=FFFF_FFFE, HI=0, EN=1, PRESC=0 -> after 2 ticks LO=0, HI=1.
  - Wrap: write all-ones to both halves -> next tick `mtime`=0.
- Write/tick collision: EN=1, PRESC=0, write MTIME_LO=5 -> next cycle reads 5, not 6; HI unchanged.
- Decode and async reset:
  - Write to BASE_ADDR+0x02 or BASE_ADDR+0x20 -> no register change, `hit`=0, `rdata`=0.
  - Assert `rst` mid-count with interrupt high -> `timer_interrupt` and `mtime` go to 0 without a clock edge.
